// File: rtl/pixel_stream_gen_if.sv
// Pixel bus between the synthetic transmitter and the receive path:
// frame valid, line valid and 10-bit pixel data.
interface pixel_stream_gen_if;
    logic       fv;
    logic       lv;
    logic [9:0] pix_data;

    modport master (output fv, lv, pix_data);
    modport slave  (input  fv, lv, pix_data);
endinterface

// File: rtl/pixel_stream_gen.sv
// Synthetic camera-side transmitter: produces fv/lv framing and 10-bit test
// patterns with programmable active size, blanking and lead-in timing.
// Every output is registered and is computed from the next-state values, so
// lv and pix_data change on the same edge with no skew between them.
module pixel_stream_gen #(
    parameter int ACTIVE_W = 640,
    parameter int ACTIVE_H = 480,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 4,
    parameter int FV_LEAD  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                pattern_sel,
    input  logic [9:0]                const_value,
    pixel_stream_gen_if.master        px,
    output logic [15:0]               frame_count,
    output logic                      busy
);
    localparam int XW    = (ACTIVE_W > 1) ? $clog2(ACTIVE_W) : 1;
    localparam int YW    = (ACTIVE_H > 1) ? $clog2(ACTIVE_H) : 1;
    localparam int BMAX0 = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BMAX  = (BMAX0 > FV_LEAD) ? BMAX0 : FV_LEAD;
    localparam int BW    = (BMAX > 1) ? $clog2(BMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_V_LEAD, S_ACTIVE, S_H_BLANK, S_V_BLANK
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [BW-1:0]   cnt_q, cnt_d;
    logic [1:0]      pat_q, pat_d;
    logic [9:0]      cval_q, cval_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic            fv_q, fv_d;
    logic            lv_q, lv_d;
    logic [9:0]      pix_q, pix_d;
    logic            busy_q, busy_d;
    logic [31:0]     x_ext, y_ext;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state, counters and pattern latch; a new frame always starts at x=y=0
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        cnt_d         = cnt_q;
        pat_d         = pat_q;
        cval_d        = cval_q;
        frame_count_d = frame_count_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_V_LEAD;
                    pat_d   = pattern_sel;
                    cval_d  = const_value;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                end
            end
            S_V_LEAD: begin
                if (cnt_q == BW'(FV_LEAD - 1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            S_ACTIVE: begin
                if (x_q == XW'(ACTIVE_W - 1)) begin
                    x_d   = '0;
                    cnt_d = '0;
                    if (y_q < YW'(ACTIVE_H - 1)) begin
                        state_d = S_H_BLANK;
                        y_d     = y_q + YW'(1);
                    end else begin
                        state_d       = S_V_BLANK;
                        frame_count_d = frame_count_q + 16'd1;
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            S_H_BLANK: begin
                if (cnt_q == BW'(H_BLANK - 1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            S_V_BLANK: begin
                if (cnt_q == BW'(V_BLANK - 1)) begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = S_V_LEAD;
                        pat_d   = pattern_sel;
                        cval_d  = const_value;
                        x_d     = '0;
                        y_d     = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from next state; pixel forced to 0 outside active lines
    always_comb begin
        x_ext  = 32'(x_d);
        y_ext  = 32'(y_d);
        fv_d   = (state_d == S_V_LEAD) || (state_d == S_ACTIVE) || (state_d == S_H_BLANK);
        lv_d   = (state_d == S_ACTIVE);
        busy_d = (state_d != S_IDLE);
        pix_d  = '0;
        if (lv_d) begin
            unique case (pat_d)
                2'd0:    pix_d = 10'(x_ext + y_ext);
                2'd1:    pix_d = cval_d;
                2'd2:    pix_d = (x_ext[3] ^ y_ext[3]) ? 10'h3FF : 10'h000;
                default: pix_d = frame_count_q[9:0];
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            cnt_q         <= '0;
            pat_q         <= '0;
            cval_q        <= '0;
            frame_count_q <= '0;
            fv_q          <= 1'b0;
            lv_q          <= 1'b0;
            pix_q         <= '0;
            busy_q        <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            cnt_q         <= cnt_d;
            pat_q         <= pat_d;
            cval_q        <= cval_d;
            frame_count_q <= frame_count_d;
            fv_q          <= fv_d;
            lv_q          <= lv_d;
            pix_q         <= pix_d;
            busy_q        <= busy_d;
        end
    end

    assign px.fv       = fv_q;
    assign px.lv       = lv_q;
    assign px.pix_data = pix_q;
    assign frame_count = frame_count_q;
    assign busy        = busy_q;
endmodule
